// File: rtl/shift_pkg.sv
// Shared definitions for the shift issue/capture stage: bus width, direction
// encodings and the packed operand entry carried through the operand FIFO.
package shift_pkg;

  localparam int DATA_W = 4;

  localparam logic SHIFT_LEFT  = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;

  typedef struct packed {
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic              dir;
  } operand_t;

endpackage

// File: rtl/shift_fifo.sv
// Synchronous DEPTH-entry FIFO with occupancy count. Push is ignored when full
// and pop is ignored when empty; there is no full-bypass.
module shift_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage is not reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/shift_issue.sv
// Operand issue and result capture around an external combinational shift
// stage: queues operand triples, drives the head to the shifter, registers a/b.
module shift_issue
  import shift_pkg::*;
#(
  parameter int DATA_W = shift_pkg::DATA_W,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_y,
  input  logic              in_dir,
  output logic [DATA_W-1:0] x_o,
  output logic [DATA_W-1:0] y_o,
  output logic              control_o,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_dir,
  output logic [PTR_W:0]    fifo_count,
  output logic [7:0]        issue_cnt
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // A producer holds valid and its data stable until ready is seen; ready
  // never depends on valid of the same port.

  localparam int ENTRY_W = 2*DATA_W + 1;

  logic [ENTRY_W-1:0] head;
  logic               push;
  logic               fire;
  logic               full;
  logic               empty;
  logic [DATA_W-1:0]  head_x;
  logic [DATA_W-1:0]  head_y;
  logic               head_dir;

  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign fire     = !empty && (!out_valid || out_ready);

  shift_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({in_x, in_y, in_dir}),
    .pop   (fire),
    .rdata (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  assign head_x   = head[ENTRY_W-1 -: DATA_W];
  assign head_y   = head[DATA_W -: DATA_W];
  assign head_dir = head[0];

  // The shifter sees a quiet all-zero left shift whenever nothing is queued.
  always_comb begin
    x_o       = '0;
    y_o       = '0;
    control_o = SHIFT_LEFT;
    if (!empty) begin
      x_o       = head_x;
      y_o       = head_y;
      control_o = head_dir;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_dir   <= 1'b0;
      issue_cnt <= '0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_a     <= a_i;
      out_b     <= b_i;
      out_dir   <= head_dir;
      issue_cnt <= issue_cnt + 8'd1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/shift_issue.md
Name: shift_issue

Overview:
- Operand issue and result capture stage placed directly upstream of the combinational 4-bit shift stage.
- Accepts {x, y, direction} operand triples over a valid/ready handshake into a small FIFO.
- Drives the FIFO head onto the shift stage's x/y/control inputs and registers the returned a/b results behind a valid/ready output port.
- Gives the pure-combinational shifter flow control, buffering and a registered output.

Parameters:
DATA_W, 4, operand/result width (matches shift stage bus width)
DEPTH, 4, operand FIFO entries; power of two, >= 2
PTR_W, 2, log2(DEPTH)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operand triple valid
in_ready  output  1  FIFO can accept an operand this cycle
in_x  input  DATA_W  operand x
in_y  input  DATA_W  operand y
in_dir  input  1  0 = shift left, 1 = shift right
x_o  output  DATA_W  to shift stage x
y_o  output  DATA_W  to shift stage y
control_o  output  1  to shift stage control
a_i  input  DATA_W  from shift stage a (combinational from x_o/control_o)
b_i  input  DATA_W  from shift stage b
out_valid  output  1  registered result valid
out_ready  input  1  downstream accepts result
out_a  output  DATA_W  registered a
out_b  output  DATA_W  registered b
out_dir  output  1  direction that produced out_a/out_b
fifo_count  output  PTR_W+1  FIFO occupancy, 0..DEPTH
issue_cnt  output  8  count of results captured, wraps 255->0

Behaviour:
- Reset (rst_n low, asynchronous): FIFO pointers, fifo_count, out_valid, out_a, out_b, out_dir and issue_cnt all clear to 0. in_ready = 1 after reset.
- in_ready = (fifo_count != DEPTH). There is no full-bypass: a push is refused when full, even if a pop occurs in the same cycle.
- Push: on in_valid && in_ready, write {in_x, in_y, in_dir} at wr_ptr and increment wr_ptr, wrapping mod DEPTH.
- Issue (combinational):
  - FIFO non-empty: x_o/y_o/control_o = head entry.
  - FIFO empty: x_o = 0, y_o = 0, control_o = 0.
- Capture condition: fire = (fifo_count != 0) && (!out_valid || out_ready).
- On fire:
  - out_a <= a_i, out_b <= b_i, out_dir <= head dir, out_valid <= 1.
  - Pop the head: rd_ptr increments mod DEPTH.
  - issue_cnt increments.
- Without fire: if out_valid && out_ready, out_valid <= 0. Otherwise out_a/out_b/out_dir/out_valid hold. Output data is stable while out_valid && !out_ready.
- fifo_count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Latency:
  - Push at edge N makes the entry the head in cycle N+1 if the FIFO was empty.
  - Capture occurs at edge N+1, so out_valid is high in the cycle after edge N+1: 2 cycles from in_valid to out_valid.
- Throughput: 1 result per cycle when out_ready is held high.
- Backpressure: with out_ready low, one result is held in the output register and up to DEPTH operands queue. in_ready drops at DEPTH.
- Result ordering is strict FIFO.
- Reset mid-operation: all queued operands and any held result are discarded. No partial outputs are produced after rst_n rises.
- Width rule: a_i/b_i are taken as-is (DATA_W bits). No sign or overflow handling occurs in this block.

Decomposition:
- Shared package (shift_pkg):
  - DATA_W default.
  - Direction constants SHIFT_LEFT = 1'b0, SHIFT_RIGHT = 1'b1.
  - Packed operand entry typedef {x, y, dir}.
- One natural sub-module: shift_fifo, a synchronous DEPTH-entry FIFO with count, full and empty.
- Top-level contents: issue muxing and the output/handshake register.
- The combinational shift stage is instantiated only in the testbench/top integration, not inside this block.

Test Plan:
- Reset check: assert rst_n low mid-stream with 3 entries queued and out_valid=1. Required: fifo_count=0, out_valid=0, issue_cnt=0 immediately; in_ready=1 after release.
- Single left shift: push x=4'h3, y=4'h5, dir=0 with the shift stage attached and out_ready=1. Required: out_valid 2 cycles later, out_a=4'hC, out_b=4'h4, out_dir=0, issue_cnt=1.
- Single right shift: push x=4'hF, y=4'h8, dir=1. Required: out_a=4'h3, out_b=4'h2, out_dir=1.
- Backpressure/full: hold out_ready=0 and push 6 operands. Required:
  - The first result is held stable in out_a/out_b.
  - fifo_count reaches 4 and in_ready=0; operands 6.. are refused.
  - Releasing out_ready drains 5 results in push order, one per cycle.
- Streaming: 20 back-to-back pushes with out_ready=1. Required:
  - in_ready stays 1 and fifo_count stays <= 1.
  - 20 in-order results arrive, the last 2 cycles after the last push.
- Counter wrap: 256 accepted results. Required: issue_cnt returns to 0.
